imem_loader: RTL
================

Name: imem_loader

Overview:
- Writes a program image into instruction memory; the Fetch stage is the reader on the other side of that memory.
- Receives a byte stream over a valid/ready interface: a 16-bit big-endian word count, then big-endian 32-bit instruction words.
- Issues one write per assembled word to the instruction-memory write port.
- Holds the CPU pipeline (`cpu_hold`) until a complete image is loaded.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest legal word count; must be ≤ 2^ADDR_W.
- TIMEOUT, 1000, maximum idle cycles allowed between accepted bytes while loading.

Ports:
- clk  input  1  system clock, all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  stalls Fetch/PC while high.
- done  output  1  level, image loaded successfully.
- error  output  1  level, load aborted.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (asynchronous, active-high) values:
  - State = IDLE.
  - rx_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_hold = 1, done = 0, error = 0, words_loaded = 0.
  - Byte counter, word-count register and timeout counter = 0.
- A byte is accepted only on a cycle where rx_valid && rx_ready.
- rx_ready is a registered function of state: 1 in LEN_HI, LEN_LO and DATA; 0 in every other state.
- States and transitions:
  - IDLE: start → LEN_HI; clears words_loaded, byte counter and timeout counter; cpu_hold = 1.
  - LEN_HI: accepted byte → len[15:8]; go to LEN_LO.
  - LEN_LO: accepted byte → len[7:0]; then:
    - len == 0 → DONE.
    - len > MAX_WORDS → ERR.
    - otherwise → DATA.
  - DATA: accepted bytes shift into the word register MSB first, byte counter 0..3. On the 4th byte → WRITE.
  - WRITE (exactly one cycle):
    - mem_we = 1, mem_addr = words_loaded[ADDR_W-1:0], mem_wdata = assembled word.
    - words_loaded increments at the end of the cycle.
    - If the new count equals len → DONE; else → DATA with byte counter = 0.
  - DONE: done = 1, cpu_hold = 0. start → LEN_HI (load restarts, done drops, cpu_hold = 1).
  - ERR: error = 1, cpu_hold stays 1. start → LEN_HI (error drops).
- Latency:
  - mem_we is asserted in the cycle immediately after the 4th byte of a word is accepted.
  - After the last word, done rises one cycle after its WRITE cycle.
- Timeout:
  - In LEN_HI, LEN_LO and DATA the timeout counter increments on every cycle without an accepted byte and clears on each accepted byte.
  - Reaching TIMEOUT → ERR. A byte accepted on the cycle the counter would reach TIMEOUT wins, and no error is raised.
- start is ignored in LEN_HI, LEN_LO, DATA and WRITE.
- mem_addr and mem_wdata hold their last values when mem_we = 0.
- Reset mid-load returns every output to its reset value immediately, with no partial write. Memory contents written before the reset are not rolled back.
- Byte order: the first byte of a word lands in bits [31:24].
- Width rule: words_loaded is ADDR_W+1 bits so that MAX_WORDS = 2^ADDR_W is representable.

Decomposition:
- Shared package `imem_loader_pkg`:
  - State enum: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
  - Constants: LEN_BYTES = 2, BYTES_PER_WORD = 4.
- One sub-module, `byte_word_packer`:
  - 8→32 shift register plus 2-bit byte counter.
  - Inputs: shift enable and clear. Outputs: word and word_full.
- The FSM, timeout counter and memory-port registers stay in `imem_loader`.

Test Plan:
- Start, then stream 00 02 | 12 34 56 78 | 9A BC DE F0 with rx_valid continuously high:
  - Two mem_we pulses: addr 0 ← 0x12345678, addr 1 ← 0x9ABCDEF0.
  - words_loaded = 2, done = 1, cpu_hold = 0.
- Stream 00 00 → DONE directly after LEN_LO; no mem_we; words_loaded = 0.
- Stream 01 01 (257 > MAX_WORDS) → error = 1, cpu_hold = 1, no mem_we; a following start clears error and reaches LEN_HI.
- 1-word load with rx_valid low for 3 cycles between bytes → same result as continuous streaming; rx_ready low only in the WRITE cycle.
- Send 00 01 12 and then stall for TIMEOUT cycles → error = 1; a byte arriving at the boundary cycle prevents the error.
- Assert rst after 2 data bytes → all outputs return to reset values at once; a fresh start then loads correctly to addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_e;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // True in the states that take bytes from the stream
    function automatic logic is_rx_state(input state_e s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA);
    endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Big-endian 8->32 packer: keeps the three leading bytes of a word and
// presents the completed word combinationally while the fourth byte is on
// the input, so the caller can register it in the same cycle.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [23:0] lead_r;
    logic [1:0]  byte_cnt_r;

    assign word      = {lead_r, byte_in};
    assign word_full = shift_en && (byte_cnt_r == LAST_BYTE);

    // Shift accepted bytes in MSB first and count position within the word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lead_r     <= 24'h000000;
            byte_cnt_r <= 2'd0;
        end else if (clear) begin
            lead_r     <= 24'h000000;
            byte_cnt_r <= 2'd0;
        end else if (shift_en) begin
            lead_r     <= {lead_r[15:0], byte_in};
            byte_cnt_r <= byte_cnt_r + 2'd1;
        end else begin
            lead_r     <= lead_r;
            byte_cnt_r <= byte_cnt_r;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian program image from a byte stream into
// instruction memory and holds the CPU until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256,
    parameter int TIMEOUT   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [15:0]     MAX_LEN  = 16'(MAX_WORDS);

    state_e              state_r;
    state_e              next_s;
    logic [15:0]         len_r;
    logic [TMO_W-1:0]    tmo_r;
    logic                rx_ready_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [31:0]         mem_wdata_r;
    logic                cpu_hold_r;
    logic                done_r;
    logic                error_r;
    logic [ADDR_W:0]     words_loaded_r;

    logic                accept_s;
    logic                start_load_s;
    logic                tmo_expire_s;
    logic [15:0]         len_rx_s;
    logic [ADDR_W:0]     wl_next_s;
    logic                last_word_s;
    logic [31:0]         word_s;
    logic                word_full_s;

    assign accept_s     = rx_valid && rx_ready_r;
    assign start_load_s = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
    // The counter would reach TIMEOUT this cycle; an accepted byte overrides it
    assign tmo_expire_s = !accept_s && (tmo_r == TMO_LAST);
    assign len_rx_s     = {len_r[15:8], rx_data};
    assign wl_next_s    = words_loaded_r + (ADDR_W + 1)'(1);
    assign last_word_s  = (16'(wl_next_s) == len_r);

    assign rx_ready     = rx_ready_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign cpu_hold     = cpu_hold_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_loaded_r;

    byte_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (accept_s && (state_r == DATA)),
        .clear     (start_load_s),
        .byte_in   (rx_data),
        .word      (word_s),
        .word_full (word_full_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_s = LEN_HI;
                else       next_s = IDLE;
            end
            LEN_HI: begin
                if (accept_s)          next_s = LEN_LO;
                else if (tmo_expire_s) next_s = ERR;
                else                   next_s = LEN_HI;
            end
            LEN_LO: begin
                if (accept_s) begin
                    if (len_rx_s == 16'd0)         next_s = DONE;
                    else if (len_rx_s > MAX_LEN)   next_s = ERR;
                    else                           next_s = DATA;
                end else if (tmo_expire_s) begin
                    next_s = ERR;
                end else begin
                    next_s = LEN_LO;
                end
            end
            DATA: begin
                if (word_full_s)       next_s = WRITE;
                else if (accept_s)     next_s = DATA;
                else if (tmo_expire_s) next_s = ERR;
                else                   next_s = DATA;
            end
            WRITE: begin
                if (last_word_s) next_s = DONE;
                else             next_s = DATA;
            end
            DONE: begin
                if (start) next_s = LEN_HI;
                else       next_s = DONE;
            end
            ERR: begin
                if (start) next_s = LEN_HI;
                else       next_s = ERR;
            end
            default: next_s = IDLE;
        endcase
    end

    // Status outputs registered from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            rx_ready_r <= is_rx_state(next_s);
            mem_we_r   <= (next_s == WRITE);
            cpu_hold_r <= (next_s != DONE);
            done_r     <= (next_s == DONE);
            error_r    <= (next_s == ERR);
        end
    end

    // Memory write port: capture address and word as the fourth byte arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'h00000000;
        end else if (state_r == DATA && word_full_s) begin
            mem_addr_r  <= words_loaded_r[ADDR_W-1:0];
            mem_wdata_r <= word_s;
        end else begin
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
        end
    end

    // Word-count header capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r <= 16'h0000;
        end else if (accept_s && state_r == LEN_HI) begin
            len_r <= {rx_data, len_r[7:0]};
        end else if (accept_s && state_r == LEN_LO) begin
            len_r <= len_rx_s;
        end else begin
            len_r <= len_r;
        end
    end

    // Count of words written in the current load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_loaded_r <= '0;
        end else if (start_load_s) begin
            words_loaded_r <= '0;
        end else if (state_r == WRITE) begin
            words_loaded_r <= wl_next_s;
        end else begin
            words_loaded_r <= words_loaded_r;
        end
    end

    // Idle-gap counter between accepted bytes while receiving
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_r <= '0;
        end else if (start_load_s) begin
            tmo_r <= '0;
        end else if (is_rx_state(state_r)) begin
            if (accept_s) tmo_r <= '0;
            else          tmo_r <= tmo_r + TMO_W'(1);
        end else begin
            tmo_r <= tmo_r;
        end
    end

endmodule
